rd_burst_ctrl: RTL and testbench

Parametrised Avalon-MM burst read master that moves a packet region from host memory into the capture FIFO. It replaces the fixed 32-bit, single-burst-at-a-time read controller. It adds configurable data/address width and maximum burst, multiple outstanding bursts limited by FIFO credit, correct waitrequest handling, range validation and abort. It sits between the control register block (start, pkt_begin, pkt_end) and the packet FIFO write port.

---
 rtl/rd_burst_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rd_burst_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_burst_ctrl.sv
// rd_burst_ctrl: Avalon-MM burst read master that copies a packet region
// [pkt_begin, pkt_end) into the capture FIFO. Several bursts can be in
// flight at once. New commands are issued only while the FIFO has room for
// every word already requested plus the new burst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; range is checked here
// S_ISSUE | presenting burst commands while credit allows
// S_DRAIN | no more commands; waiting for outstanding words to land
// S_DONE  | one-cycle completion pulse, then back to S_IDLE
module rd_burst_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int BURST_W   = 16,
    parameter int CREDIT_W  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   pkt_begin,
    input  logic [ADDR_W-1:0]   pkt_end,
    input  logic [CREDIT_W-1:0] fifo_free,
    output logic [DATA_W-1:0]   fifo_in,
    output logic                wr_to_fifo,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic [BURST_W-1:0]  burstcount,
    input  logic [DATA_W-1:0]   readdata,
    input  logic                readdatavalid,
    input  logic                waitrequest
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int LEN_W = $clog2(MAX_BURST) + 1;
    localparam int OUT_W = CREDIT_W + 1;
    localparam int SUM_W = OUT_W + LEN_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [ADDR_W-1:0]   remaining, remaining_nxt;
    logic [OUT_W-1:0]    outstanding, outstanding_nxt;
    logic                abort_pend, abort_pend_nxt;
    logic [ADDR_W-1:0]   address_nxt;
    logic [BURST_W-1:0]  burstcount_nxt;
    logic                read_nxt;
    logic                busy_nxt, done_nxt, err_nxt;

    logic                accept;
    logic                rdv_live;
    logic [ADDR_W-1:0]   span;
    logic                range_ok;
    logic                try_issue;
    logic [LEN_W-1:0]    len;
    logic [SUM_W-1:0]    need;

    assign accept = read && !waitrequest;
    // Return data only counts while words are owed; after a reset the slave
    // may still deliver stale beats and those must not underflow the counter.
    assign rdv_live = readdatavalid && (outstanding != '0);
    assign span     = pkt_end - pkt_begin;
    assign range_ok = (pkt_end > pkt_begin)
                   && ((pkt_begin & ADDR_W'(BYTES - 1)) == '0)
                   && ((pkt_end   & ADDR_W'(BYTES - 1)) == '0);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        remaining_nxt   = remaining;
        outstanding_nxt = outstanding - OUT_W'(rdv_live);
        abort_pend_nxt  = abort_pend;
        read_nxt        = read;
        address_nxt     = address;
        burstcount_nxt  = burstcount;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        err_nxt         = 1'b0;
        try_issue       = 1'b0;
        len             = '0;
        need            = '0;

        case (state)
            S_IDLE: begin
                abort_pend_nxt = 1'b0;
                if (start) begin
                    if (range_ok) begin
                        addr_nxt      = pkt_begin;
                        remaining_nxt = span >> BSH;
                        busy_nxt      = 1'b1;
                        state_nxt     = S_ISSUE;
                        try_issue     = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (read && waitrequest) begin
                    // Stalled command stays on the bus untouched; an abort
                    // seen now takes effect once the command is taken.
                    if (abort) abort_pend_nxt = 1'b1;
                end else begin
                    if (accept) begin
                        addr_nxt        = addr + (ADDR_W'(burstcount) << BSH);
                        remaining_nxt   = remaining - ADDR_W'(burstcount);
                        outstanding_nxt = outstanding_nxt + OUT_W'(burstcount);
                    end
                    read_nxt = 1'b0;
                    if ((remaining_nxt == '0) || abort || abort_pend) begin
                        state_nxt      = S_DRAIN;
                        abort_pend_nxt = 1'b0;
                    end else begin
                        try_issue = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last beat is still sitting in the fifo_in register this
                // cycle; done rises on the following cycle, after that write.
                if ((outstanding == '0) && !readdatavalid) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Command for the next cycle is built from the already-updated
        // pointers, so a fresh burst can follow an acceptance back to back.
        // Credit counts every word owed, including those in the write stage.
        if (try_issue) begin
            len  = (remaining_nxt >= ADDR_W'(MAX_BURST)) ? LEN_W'(MAX_BURST)
                                                         : remaining_nxt[LEN_W-1:0];
            need = SUM_W'(outstanding_nxt) + SUM_W'(rdv_live)
                 + SUM_W'(wr_to_fifo) + SUM_W'(len);
            if (SUM_W'(fifo_free) >= need) begin
                read_nxt       = 1'b1;
                address_nxt    = addr_nxt;
                burstcount_nxt = BURST_W'(len);
            end
        end
    end

    // Control state, counters and command/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            outstanding <= '0;
            abort_pend  <= 1'b0;
            address     <= '0;
            burstcount  <= '0;
            read        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= remaining_nxt;
            outstanding <= outstanding_nxt;
            abort_pend  <= abort_pend_nxt;
            address     <= address_nxt;
            burstcount  <= burstcount_nxt;
            read        <= read_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            err         <= err_nxt;
        end
    end

    // Return-data stage: one registered FIFO write per owed beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_in    <= '0;
            wr_to_fifo <= 1'b0;
        end else begin
            wr_to_fifo <= rdv_live;
            if (rdv_live) fifo_in <= readdata;
        end
    end

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Directed bench for rd_burst_ctrl with a small Avalon slave responder.
module tb_rd_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] pkt_begin = '0;
    logic [31:0] pkt_end = '0;
    logic [9:0]  fifo_free = 10'd512;
    logic [31:0] fifo_in;
    logic        wr_to_fifo, busy, done, err;
    logic [31:0] address;
    logic        read;
    logic [15:0] burstcount;
    logic [31:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest = 1'b0;

    int ncomp = 0;
    int nfail = 0;

    logic [31:0] wq[$];
    logic [31:0] cmd_a[$];
    int          cmd_l[$];
    logic [31:0] cap[$];
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_rdv_cyc = 0;
    int          done_cyc = 0;

    rd_burst_ctrl #(
        .DATA_W(32), .ADDR_W(32), .MAX_BURST(16), .BURST_W(16), .CREDIT_W(10)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end), .fifo_free(fifo_free),
        .fifo_in(fifo_in), .wr_to_fifo(wr_to_fifo), .busy(busy), .done(done),
        .err(err), .address(address), .read(read), .burstcount(burstcount),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    // Slave command capture and FIFO-side monitor.
    always @(posedge clk) begin
        cyc++;
        if (read && !waitrequest && !reset) begin
            cmd_a.push_back(address);
            cmd_l.push_back(int'(burstcount));
            for (int i = 0; i < int'(burstcount); i++)
                wq.push_back(address + 32'(4 * i));
        end
        if (readdatavalid) last_rdv_cyc = cyc;
        if (wr_to_fifo) cap.push_back(fifo_in);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Slave data return: one beat per cycle, starting the cycle after acceptance.
    always @(negedge clk) begin
        if (wq.size() != 0) begin
            readdata      = pat(wq.pop_front());
            readdatavalid = 1'b1;
        end else begin
            readdata      = '0;
            readdatavalid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},       64'(busy),       64'(0));
        check({tag, " read"},       64'(read),       64'(0));
        check({tag, " done"},       64'(done),       64'(0));
        check({tag, " err"},        64'(err),        64'(0));
        check({tag, " wr_to_fifo"}, 64'(wr_to_fifo), 64'(0));
        check({tag, " fifo_in"},    64'(fifo_in),    64'(0));
        check({tag, " address"},    64'(address),    64'(0));
        check({tag, " burstcount"}, 64'(burstcount), 64'(0));
    endtask

    task automatic check_cmd(input string tag, input logic [31:0] a, input logic [15:0] bc);
        check({tag, " read"},       64'(read),       64'(1));
        check({tag, " address"},    64'(address),    64'(a));
        check({tag, " burstcount"}, 64'(burstcount), 64'(bc));
    endtask

    task automatic check_stream(input string tag, input int base, input logic [31:0] a0, input int n);
        check({tag, " words"}, 64'(cap.size() - base), 64'(n));
        for (int i = 0; i < n; i++)
            if (base + i < cap.size())
                check($sformatf("%s word%0d", tag, i), 64'(cap[base + i]), 64'(pat(a0 + 32'(4 * i))));
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'(1));
        @(negedge clk);
        check({tag, " busy_after"}, 64'(busy), 64'(0));
        check({tag, " done_1cyc"},  64'(done), 64'(0));
        check({tag, " done_lat"},   64'(done_cyc - last_rdv_cyc), 64'(2));
    endtask

    // Range 0x1000-0x1058: bursts (0x1000,16) then (0x1040,6), optional stall.
    task automatic run_nominal(input string tag, input int nwait);
        int cb, kb, db;
        cb = cap.size();
        kb = cmd_a.size();
        db = done_cnt;
        pkt_begin   = 32'h1000;
        pkt_end     = 32'h1058;
        waitrequest = (nwait > 0);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy"}, 64'(busy), 64'(1));
        check_cmd({tag, " cmd0"}, 32'h1000, 16'd16);
        for (int i = 1; i < nwait; i++) begin
            @(negedge clk);
            check_cmd($sformatf("%s hold%0d", tag, i), 32'h1000, 16'd16);
        end
        waitrequest = 1'b0;
        @(negedge clk);
        check_cmd({tag, " cmd1"}, 32'h1040, 16'd6);
        @(negedge clk);
        check({tag, " read_off"}, 64'(read), 64'(0));
        wait_done(tag);
        check({tag, " ncmd"}, 64'(cmd_a.size() - kb), 64'(2));
        if (cmd_a.size() >= kb + 2) begin
            check({tag, " c0a"}, 64'(cmd_a[kb]),     64'(32'h1000));
            check({tag, " c0l"}, 64'(cmd_l[kb]),     64'(16));
            check({tag, " c1a"}, 64'(cmd_a[kb + 1]), 64'(32'h1040));
            check({tag, " c1l"}, 64'(cmd_l[kb + 1]), 64'(6));
        end
        check_stream(tag, cb, 32'h1000, 22);
        repeat (3) @(negedge clk);
        check({tag, " ndone"}, 64'(done_cnt - db), 64'(1));
    endtask

    initial begin
        int cb, kb, db;

        #2 reset = 1'b1;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_nominal("nominal", 0);
        run_nominal("stall", 3);

        // Credit gating: 10 free words cannot hold a 16-word burst.
        cb = cap.size(); kb = cmd_a.size();
        fifo_free = 10'd10;
        pkt_begin = 32'h0; pkt_end = 32'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("credit busy", 64'(busy), 64'(1));
        check("credit read0", 64'(read), 64'(0));
        @(negedge clk);
        check("credit read1", 64'(read), 64'(0));
        fifo_free = 10'd16;
        @(negedge clk);
        check_cmd("credit cmd", 32'h0, 16'd16);
        @(negedge clk);
        check("credit read_off", 64'(read), 64'(0));
        wait_done("credit");
        check("credit ncmd", 64'(cmd_a.size() - kb), 64'(1));
        check_stream("credit", cb, 32'h0, 16);
        fifo_free = 10'd512;

        // Invalid ranges: empty, then misaligned.
        kb = cmd_a.size(); db = done_cnt;
        pkt_begin = 32'h2000; pkt_end = 32'h2000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty err", 64'(err), 64'(1));
        check("empty busy", 64'(busy), 64'(0));
        check("empty read", 64'(read), 64'(0));
        @(negedge clk);
        check("empty err_pulse", 64'(err), 64'(0));
        pkt_begin = 32'h2002; pkt_end = 32'h2100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("misalign err", 64'(err), 64'(1));
        check("misalign read", 64'(read), 64'(0));
        check("misalign busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        check("invalid ndone", 64'(done_cnt - db), 64'(0));
        check("invalid ncmd", 64'(cmd_a.size() - kb), 64'(0));

        // Abort coinciding with the first acceptance.
        cb = cap.size(); kb = cmd_a.size();
        pkt_begin = 32'h0; pkt_end = 32'h400; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cmd("abort cmd", 32'h0, 16'd16);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort read_off", 64'(read), 64'(0));
        check("abort busy", 64'(busy), 64'(1));
        wait_done("abort");
        check("abort ncmd", 64'(cmd_a.size() - kb), 64'(1));
        check_stream("abort", cb, 32'h0, 16);

        // Abort while the first command is stalled on waitrequest.
        cb = cap.size(); kb = cmd_a.size();
        waitrequest = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cmd("abwait cmd", 32'h0, 16'd16);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_cmd("abwait hold", 32'h0, 16'd16);
        waitrequest = 1'b0;
        @(negedge clk);
        check("abwait read_off", 64'(read), 64'(0));
        wait_done("abwait");
        check("abwait ncmd", 64'(cmd_a.size() - kb), 64'(1));
        check_stream("abwait", cb, 32'h0, 16);

        // Reset during the second burst, stale data afterwards, then rerun.
        pkt_begin = 32'h1000; pkt_end = 32'h1058; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        cb = cap.size();
        reset = 1'b1;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60 && wq.size() != 0; i++) @(negedge clk);
        check("stale drained", 64'(wq.size()), 64'(0));
        repeat (2) @(negedge clk);
        check("stale nowrite", 64'(cap.size() - cb), 64'(0));
        check("stale busy", 64'(busy), 64'(0));
        run_nominal("rerun", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
